// File: rtl/riscv_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a one-byte holding register in front of the shifter.
// Define RISCV_UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module riscv_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       i_riscv_clk,
    input  logic       i_riscv_rst,
    input  logic       i_riscv_uart_tx_wren,
    input  logic [7:0] i_riscv_uart_tx_wdata,
    output logic       o_riscv_uart_tx_busy,
    output logic       o_riscv_uart_tx_serial,
    output logic       o_riscv_uart_tx_done
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef RISCV_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       hold_q, hold_d;
    logic             busy_q, busy_d;
    logic             serial_q, serial_d;
    logic             done_q, done_d;
    logic             cnt_term;

    assign cnt_term = (cnt_q == CNT_MAX);

    // Write handshake: wren is a one-cycle store strobe with no back-pressure. It is
    // accepted only when the registered busy is low; otherwise it is silently dropped.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        hold_d   = hold_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        serial_d = 1'b1;

        if (i_riscv_uart_tx_wren && !busy_q) begin
            hold_d = i_riscv_uart_tx_wdata;
            busy_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (busy_q) begin
                    shift_d = hold_q;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_term) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_term) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef RISCV_UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef RISCV_UART_TX_PARITY_EN
            PARITY: begin
                if (cnt_term) begin
                    cnt_d   = '0;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (cnt_term) begin
                    done_d = 1'b1;
                    cnt_d  = '0;
                    // A queued byte starts immediately so back-to-back frames have no idle gap.
                    if (busy_q) begin
                        shift_d = hold_q;
                        busy_d  = 1'b0;
                        bit_d   = '0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The line is registered, so it is derived from the state being entered.
        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[bit_d];
`ifdef RISCV_UART_TX_PARITY_EN
            PARITY:  serial_d = ^shift_d;
`endif
            default: serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_riscv_clk) begin
        if (i_riscv_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            hold_q   <= '0;
            busy_q   <= 1'b0;
            serial_q <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            hold_q   <= hold_d;
            busy_q   <= busy_d;
            serial_q <= serial_d;
            done_q   <= done_d;
        end
    end

    assign o_riscv_uart_tx_busy   = busy_q;
    assign o_riscv_uart_tx_serial = serial_q;
    assign o_riscv_uart_tx_done   = done_q;

endmodule
